// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared constants and FSM state type for the random-byte arbiter
package rng_pkg;

    localparam int          LFSR_W       = 8;
    localparam logic [7:0]  DEFAULT_SEED = 8'hD5;
    // Feedback taps x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3
    localparam logic [7:0]  TAP_MASK     = 8'hB8;

    typedef enum logic {
        IDLE,
        COOL
    } arb_state_t;

endpackage

// File: rtl/lfsr8_core.sv
// rtl/lfsr8_core.sv - 8-bit maximal-length LFSR with seed load and zero-seed substitution
module lfsr8_core
    import rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    // An all-zero state would lock the LFSR, so a zero seed is replaced.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (load) begin
            q <= (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            q <= {q[LFSR_W-2:0], ^(q & TAP_MASK)};
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - round-robin arbiter handing one LFSR byte per grant, with cooldown
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int                N_REQ = 4,
    parameter int                GAP   = 2,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic                     seed_load,
    input  logic [LFSR_W-1:0]        seed_val,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rnd_valid,
    output logic [LFSR_W-1:0]        rnd,
    output logic [$clog2(N_REQ)-1:0] rnd_id,
    output logic                     busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (GAP < 1) ? 1 : $clog2(GAP + 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   ptr_next;
    logic              found;
    logic              fire;
    logic [LFSR_W-1:0] lfsr_q;
    int                cand;

    // Search upward from ptr with wraparound; first set request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = ID_W'(cand);
            end
        end
    end

    assign ptr_next = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign fire     = (state == IDLE) && found && !seed_load;
    assign busy     = (state == COOL);

    lfsr8_core #(
        .SEED(SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (fire),
        .load     (seed_load),
        .load_val (seed_val),
        .q        (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd       <= '0;
            rnd_id    <= '0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        gnt[win]  <= 1'b1;
                        rnd_valid <= 1'b1;
                        rnd       <= lfsr_q;
                        rnd_id    <= win;
                        ptr       <= ptr_next;
                        if (GAP > 0) begin
                            state <= COOL;
                            cnt   <= CNT_W'(GAP);
                        end
                    end
                end
                COOL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - directed self-checking bench for rng_arbiter (GAP=2 and GAP=0 instances)
module tb_rng_arbiter;

    logic       clk;
    logic       rst;
    logic       seed_load;
    logic [7:0] seed_val;

    logic [3:0] req2, gnt2;
    logic       rnd_valid2, busy2;
    logic [7:0] rnd2;
    logic [1:0] rnd_id2;

    logic [3:0] req0, gnt0;
    logic       rnd_valid0, busy0;
    logic [7:0] rnd0;
    logic [1:0] rnd_id0;

    int errors = 0;
    int checks = 0;

    logic [7:0] vals [0:255];
    logic       seen [0:255];
    int         zero_hits;
    int         dup_hits;
    int         valid_miss;

    rng_arbiter #(.N_REQ(4), .GAP(2), .SEED(8'hD5)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .seed_load(seed_load), .seed_val(seed_val),
        .gnt(gnt2), .rnd_valid(rnd_valid2), .rnd(rnd2), .rnd_id(rnd_id2), .busy(busy2)
    );

    rng_arbiter #(.N_REQ(4), .GAP(0), .SEED(8'hD5)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .seed_load(seed_load), .seed_val(seed_val),
        .gnt(gnt0), .rnd_valid(rnd_valid0), .rnd(rnd0), .rnd_id(rnd_id0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; seed_load = 1'b0; seed_val = 8'h00; req2 = '0; req0 = '0;
        tick(); tick();
        chk("rst_gnt", 32'(gnt2), 32'h0);
        chk("rst_valid", 32'(rnd_valid2), 32'h0);
        chk("rst_rnd", 32'(rnd2), 32'h0);
        chk("rst_id", 32'(rnd_id2), 32'h0);
        chk("rst_busy", 32'(busy2), 32'h0);
        rst = 1'b0;

        // GAP=2, single requester held
        req2 = 4'b0100;
        tick();
        chk("g2_gnt1", 32'(gnt2), 32'h4);
        chk("g2_valid1", 32'(rnd_valid2), 32'h1);
        chk("g2_rnd1", 32'(rnd2), 32'hD5);
        chk("g2_id1", 32'(rnd_id2), 32'h2);
        chk("g2_busy_a", 32'(busy2), 32'h1);
        tick();
        chk("g2_gap_gnt_a", 32'(gnt2), 32'h0);
        chk("g2_busy_b", 32'(busy2), 32'h1);
        tick();
        chk("g2_gap_gnt_b", 32'(gnt2), 32'h0);
        chk("g2_busy_c", 32'(busy2), 32'h0);
        tick();
        chk("g2_gnt2", 32'(gnt2), 32'h4);
        chk("g2_rnd2", 32'(rnd2), 32'hAA);
        req2 = '0;
        tick();
        chk("g2_hold_rnd", 32'(rnd2), 32'hAA);
        chk("g2_hold_valid", 32'(rnd_valid2), 32'h0);

        // GAP=0, all requesters held: back-to-back rotation
        req0 = 4'b1111;
        tick();
        chk("g0_id0", 32'(rnd_id0), 32'h0); chk("g0_rnd0", 32'(rnd0), 32'hD5);
        chk("g0_gnt0", 32'(gnt0), 32'h1);
        tick();
        chk("g0_id1", 32'(rnd_id0), 32'h1); chk("g0_rnd1", 32'(rnd0), 32'hAA);
        chk("g0_gnt1", 32'(gnt0), 32'h2);
        tick();
        chk("g0_id2", 32'(rnd_id0), 32'h2); chk("g0_rnd2", 32'(rnd0), 32'h55);
        tick();
        chk("g0_id3", 32'(rnd_id0), 32'h3); chk("g0_rnd3", 32'(rnd0), 32'hAB);
        chk("g0_gnt3", 32'(gnt0), 32'h8);
        tick();
        chk("g0_id4", 32'(rnd_id0), 32'h0); chk("g0_rnd4", 32'(rnd0), 32'h57);
        chk("g0_busy", 32'(busy0), 32'h0);
        req0 = '0;
        tick();
        chk("g0_idle_gnt", 32'(gnt0), 32'h0);
        chk("g0_idle_rnd", 32'(rnd0), 32'h57);
        chk("g0_idle_id", 32'(rnd_id0), 32'h0);

        // Zero seed substitutes the default seed
        seed_load = 1'b1; seed_val = 8'h00;
        tick();
        seed_load = 1'b0;
        req2 = 4'b0001;
        tick();
        chk("zs_gnt", 32'(gnt2), 32'h1);
        chk("zs_rnd", 32'(rnd2), 32'hD5);
        chk("zs_id", 32'(rnd_id2), 32'h0);
        req2 = '0;

        // Seed load collides with a request in IDLE; dut2 is in COOL meanwhile
        seed_load = 1'b1; seed_val = 8'h3C; req0 = 4'b0001;
        tick();
        chk("sl_no_gnt", 32'(gnt0), 32'h0);
        chk("sl_no_valid", 32'(rnd_valid0), 32'h0);
        chk("sl_busy2", 32'(busy2), 32'h1);
        seed_load = 1'b0; seed_val = 8'h00;
        tick();
        chk("sl_gnt", 32'(gnt0), 32'h1);
        chk("sl_rnd", 32'(rnd0), 32'h3C);
        chk("sl_cool_done", 32'(busy2), 32'h0);
        req0 = '0;
        req2 = 4'b0010;
        tick();
        chk("slc_gnt", 32'(gnt2), 32'h2);
        chk("slc_rnd", 32'(rnd2), 32'h3C);
        chk("slc_id", 32'(rnd_id2), 32'h1);
        chk("slc_busy", 32'(busy2), 32'h1);
        req2 = '0;

        // Reset in the middle of a cooldown
        rst = 1'b1;
        tick();
        chk("rc_gnt", 32'(gnt2), 32'h0);
        chk("rc_busy", 32'(busy2), 32'h0);
        chk("rc_rnd", 32'(rnd2), 32'h0);
        chk("rc_id", 32'(rnd_id2), 32'h0);
        rst = 1'b0;
        req2 = 4'b1010;
        tick();
        chk("rc_first_gnt", 32'(gnt2), 32'h2);
        chk("rc_first_rnd", 32'(rnd2), 32'hD5);
        chk("rc_first_id", 32'(rnd_id2), 32'h1);
        req2 = '0;

        // Free run: 256 consecutive grants from one requester with GAP=0
        req0 = 4'b0001;
        zero_hits = 0; dup_hits = 0; valid_miss = 0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 256; k++) begin
            tick();
            vals[k] = rnd0;
            if (rnd_valid0 !== 1'b1 || gnt0 !== 4'b0001) valid_miss++;
        end
        req0 = '0;
        for (int k = 0; k < 255; k++) begin
            if (vals[k] == 8'h00) zero_hits++;
            if (seen[vals[k]]) dup_hits++;
            seen[vals[k]] = 1'b1;
        end
        chk("fr_first", 32'(vals[0]), 32'hD5);
        chk("fr_valid_each", 32'(valid_miss), 32'h0);
        chk("fr_no_zero", 32'(zero_hits), 32'h0);
        chk("fr_no_repeat", 32'(dup_hits), 32'h0);
        chk("fr_wrap", 32'(vals[255]), 32'hD5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
